// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: state encoding and
// the default datapath width / reset address used by every file of the block.
package pc_seq_pkg;

    localparam int          DEFAULT_WIDTH    = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sequencer states; encodings are fixed so that debug probes of the
    // state register read the same on every build.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory request/acknowledge handshake between the sequencer
// (master, raises the request for address pc) and the instruction memory
// (slave, acknowledges when data for that pc is available).
interface pc_sequencer_if;

    logic imem_req;
    logic imem_ack;

    modport master (output imem_req, input imem_ack);
    modport slave  (input imem_req, output imem_ack);

endinterface

// File: rtl/pc_sequencer_next_sel.sv
// Combinational next-PC selection. Jump beats a taken branch, a taken branch
// beats sequential flow; any non-sequential choice is reported as a redirect
// so the sequencer can flush the datapath.
module pc_next_sel
    import pc_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             branch,
    input  logic             zero,
    input  logic             jump,
    input  logic [WIDTH-1:0] branch_end,
    input  logic [WIDTH-1:0] jump_end,
    output logic [WIDTH-1:0] pc_plus_one,
    output logic [WIDTH-1:0] next_pc,
    output logic             redirect
);

    // Pick the successor address; the increment simply wraps with no carry out.
    always_comb begin
        pc_plus_one = pc + WIDTH'(1);
        next_pc     = pc_plus_one;
        redirect    = 1'b0;
        if (jump) begin
            next_pc  = jump_end;
            redirect = 1'b1;
        end else if (branch && zero) begin
            next_pc  = branch_end;
            redirect = 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, fetches each instruction through the
// imem handshake, exposes it to the datapath for a single execute cycle, then
// advances, redirects (with a one-cycle flush) or stops for good on halt.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int             WIDTH    = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic               clock,
    input  logic               reset_n,
    pc_sequencer_if.master     imem,
    input  logic               branch,
    input  logic               zero,
    input  logic               jump,
    input  logic [WIDTH-1:0]   branchEnd,
    input  logic [WIDTH-1:0]   jumpEnd,
    input  logic               halt,
    output logic [WIDTH-1:0]   pc,
    output logic [WIDTH-1:0]   pcmais,
    output logic               instr_valid,
    output logic               flush,
    output logic               halted,
    output logic [WIDTH-1:0]   instrCount
);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [WIDTH-1:0] next_pc_sel;
    logic             redirect;

    pc_next_sel #(
        .WIDTH (WIDTH)
    ) u_next_sel (
        .pc          (pc),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .branch_end  (branchEnd),
        .jump_end    (jumpEnd),
        .pc_plus_one (pcmais),
        .next_pc     (next_pc_sel),
        .redirect    (redirect)
    );

    // State register; reset wins in every state, discarding any pending ack.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the Moore outputs, so request and valid can never overlap.
    always_comb begin
        state_next    = state;
        imem.imem_req = 1'b0;
        instr_valid   = 1'b0;
        halted        = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem.imem_req = 1'b1;
                if (imem.imem_ack) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                instr_valid = 1'b1;
                state_next  = halt ? HALT : FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // PC, flush and retire counter only move at the end of an execute cycle;
    // flush therefore lasts exactly one cycle even if the following fetch stalls.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc         <= RESET_PC;
            flush      <= 1'b0;
            instrCount <= '0;
        end else begin
            flush <= 1'b0;
            if (state == EXEC) begin
                instrCount <= instrCount + WIDTH'(1);
                if (!halt) begin
                    pc    <= next_pc_sel;
                    flush <= redirect;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. A driver issues directed fetch/execute
// vectors and queues the expected execute-cycle view; a monitor pops and
// compares whenever the sequencer presents an instruction. Two extra instances
// cover PC wrap at full width and retire-counter wrap at a narrow width.
module tb_pc_sequencer;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        first_flush;
        int          req_cycles;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Main instance stimulus and observation
    logic        reset_n;
    logic        branch, zero, jump, halt;
    logic [31:0] branch_end, jump_end;
    logic [31:0] pc_a, pcmais_a, count_a;
    logic        valid_a, flush_a, halted_a;
    pc_sequencer_if bus_a();

    // Wrap instances share a reset and always acknowledge
    logic        reset_w;
    logic [31:0] pc_b, pcmais_b, count_b;
    logic        valid_b, flush_b, halted_b;
    logic [3:0]  pc_c, pcmais_c, count_c;
    logic        valid_c, flush_c, halted_c;
    pc_sequencer_if bus_b();
    pc_sequencer_if bus_c();
    assign bus_b.imem_ack = 1'b1;
    assign bus_c.imem_ack = 1'b1;

    pc_sequencer #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .reset_n(reset_n), .imem(bus_a),
        .branch(branch), .zero(zero), .jump(jump),
        .branchEnd(branch_end), .jumpEnd(jump_end), .halt(halt),
        .pc(pc_a), .pcmais(pcmais_a), .instr_valid(valid_a),
        .flush(flush_a), .halted(halted_a), .instrCount(count_a)
    );

    pc_sequencer #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFF)) dut_wrap (
        .clock(clock), .reset_n(reset_w), .imem(bus_b),
        .branch(1'b0), .zero(1'b0), .jump(1'b0),
        .branchEnd(32'h0), .jumpEnd(32'h0), .halt(1'b0),
        .pc(pc_b), .pcmais(pcmais_b), .instr_valid(valid_b),
        .flush(flush_b), .halted(halted_b), .instrCount(count_b)
    );

    pc_sequencer #(.WIDTH(4), .RESET_PC(4'hF)) dut_narrow (
        .clock(clock), .reset_n(reset_w), .imem(bus_c),
        .branch(1'b0), .zero(1'b0), .jump(1'b0),
        .branchEnd(4'h0), .jumpEnd(4'h0), .halt(1'b0),
        .pc(pc_c), .pcmais(pcmais_c), .instr_valid(valid_c),
        .flush(flush_c), .halted(halted_c), .instrCount(count_c)
    );

    exp_t exp_q[$];
    int   checks_total  = 0;
    int   checks_passed = 0;
    logic overlap_seen  = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Issue one instruction: wait for the request, withhold ack for 'delay'
    // cycles, then present the control flags during the execute cycle.
    task automatic applyStimulus(input int delay, input logic br, input logic z,
                                 input logic jp, input logic hl,
                                 input logic [31:0] br_end_v, input logic [31:0] jp_end_v,
                                 input logic [31:0] exp_pc, input logic [31:0] exp_cnt,
                                 input logic exp_ff, input logic rst_exec);
        int   guard = 0;
        exp_t e;
        while (!bus_a.imem_req && guard < 10) begin
            @(negedge clock);
            guard++;
        end
        if (!bus_a.imem_req) begin
            checkOutput("fetch_timeout", 32'(bus_a.imem_req), 32'd1);
            return;
        end
        e.pc          = exp_pc;
        e.cnt         = exp_cnt;
        e.first_flush = exp_ff;
        e.req_cycles  = delay + 1;
        exp_q.push_back(e);
        for (int i = 0; i <= delay; i++) begin
            bus_a.imem_ack = (i == delay);
            @(negedge clock);
        end
        bus_a.imem_ack = 1'b0;
        branch     = br;
        zero       = z;
        jump       = jp;
        halt       = hl;
        branch_end = br_end_v;
        jump_end   = jp_end_v;
        if (rst_exec) reset_n = 1'b0;
        @(negedge clock);
        branch = 1'b0;
        zero   = 1'b0;
        jump   = 1'b0;
        halt   = 1'b0;
    endtask

    task automatic checkResetA(input string tag);
        checkOutput({tag, "_pc"},      pc_a,                   32'h0);
        checkOutput({tag, "_pcmais"},  pcmais_a,               32'h1);
        checkOutput({tag, "_req"},     32'(bus_a.imem_req),    32'h0);
        checkOutput({tag, "_valid"},   32'(valid_a),           32'h0);
        checkOutput({tag, "_flush"},   32'(flush_a),           32'h0);
        checkOutput({tag, "_halted"},  32'(halted_a),          32'h0);
        checkOutput({tag, "_count"},   count_a,                32'h0);
    endtask

    // Monitor: tracks each fetch phase and checks every execute cycle
    initial begin : monitor
        logic        in_fetch    = 1'b0;
        logic        first_flush = 1'b0;
        logic        late_flush  = 1'b0;
        logic        pc_moved    = 1'b0;
        logic [31:0] fetch_pc    = '0;
        int          req_cycles  = 0;
        exp_t        e;
        forever begin
            @(negedge clock);
            if (bus_a.imem_req && valid_a) overlap_seen = 1'b1;
            if (bus_a.imem_req) begin
                if (!in_fetch) begin
                    first_flush = flush_a;
                    late_flush  = 1'b0;
                    pc_moved    = 1'b0;
                    fetch_pc    = pc_a;
                    req_cycles  = 1;
                end else begin
                    req_cycles++;
                    if (flush_a) late_flush = 1'b1;
                    if (pc_a != fetch_pc) pc_moved = 1'b1;
                end
                in_fetch = 1'b1;
            end else begin
                in_fetch = 1'b0;
            end
            if (valid_a) begin
                checkOutput("exp_queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checkOutput("exec_pc",         pc_a,              e.pc);
                    checkOutput("exec_pcmais",     pcmais_a,          e.pc + 32'd1);
                    checkOutput("exec_count",      count_a,           e.cnt);
                    checkOutput("fetch_flush",     32'(first_flush),  32'(e.first_flush));
                    checkOutput("stall_flush",     32'(late_flush),   32'd0);
                    checkOutput("stall_pc_moved",  32'(pc_moved),     32'd0);
                    checkOutput("req_cycles",      32'(req_cycles),   32'(e.req_cycles));
                end
            end
        end
    end

    // Main sequence: wrap instances first, then the directed program on the main instance
    initial begin : stimulus
        int guard;
        reset_n        = 1'b0;
        reset_w        = 1'b0;
        branch         = 1'b0;
        zero           = 1'b0;
        jump           = 1'b0;
        halt           = 1'b0;
        branch_end     = '0;
        jump_end       = '0;
        bus_a.imem_ack = 1'b0;
        repeat (3) @(negedge clock);

        checkOutput("b_reset_pc",     pc_b,                 32'hFFFF_FFFF);
        checkOutput("b_reset_pcmais", pcmais_b,             32'h0);
        checkOutput("b_reset_req",    32'(bus_b.imem_req),  32'h0);
        checkOutput("b_reset_halted", 32'(halted_b),        32'h0);
        checkOutput("c_reset_pcmais", 32'(pcmais_c),        32'h0);
        checkOutput("c_reset_count",  32'(count_c),         32'h0);
        checkOutput("c_reset_req",    32'(bus_c.imem_req),  32'h0);
        checkOutput("c_reset_flush",  32'(flush_c),         32'h0);
        checkOutput("c_reset_halted", 32'(halted_c),        32'h0);
        reset_w = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            guard = 0;
            @(negedge clock);
            while (!valid_c && guard < 8) begin
                @(negedge clock);
                guard++;
            end
            if (!valid_c) begin
                checkOutput("c_exec_timeout", 32'(valid_c), 32'd1);
                break;
            end
            if (k == 0) begin
                checkOutput("b_exec_pc",    pc_b,           32'hFFFF_FFFF);
                checkOutput("b_exec_valid", 32'(valid_b),   32'd1);
                checkOutput("b_exec_count", count_b,        32'h0);
                @(negedge clock);
                checkOutput("b_wrap_pc",     pc_b,          32'h0);
                checkOutput("b_wrap_pcmais", pcmais_b,      32'h1);
                checkOutput("b_wrap_flush",  32'(flush_b),  32'h0);
            end
            if (k == 15) checkOutput("c_count_max", 32'(count_c), 32'hF);
            if (k == 16) begin
                checkOutput("c_count_wrap", 32'(count_c), 32'h0);
                checkOutput("c_pc_wrap",    32'(pc_c),    32'hF);
            end
        end
        reset_w = 1'b0;

        checkResetA("reset");
        reset_n = 1'b1;
        //            dly br z  jp hl br_end        jp_end        pc            cnt  ff rst
        applyStimulus(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0,   0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h1,        1,   0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h2,        2,   0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h3,        3,   0, 0);
        applyStimulus(0, 1, 1, 0, 0, 32'h20,       32'h0,        32'h4,        4,   0, 0);
        applyStimulus(0, 0, 0, 1, 0, 32'h0,        32'h4,        32'h20,       5,   1, 0);
        applyStimulus(0, 1, 0, 0, 0, 32'h20,       32'h0,        32'h4,        6,   1, 0);
        applyStimulus(3, 1, 1, 1, 0, 32'h20,       32'h100,      32'h5,        7,   0, 0);
        applyStimulus(3, 0, 0, 0, 0, 32'h0,        32'h0,        32'h100,      8,   1, 0);
        applyStimulus(1, 0, 1, 0, 0, 32'h0,        32'h0,        32'h101,      9,   0, 0);
        applyStimulus(0, 0, 0, 1, 1, 32'h0,        32'h300,      32'h102,      10,  0, 0);

        bus_a.imem_ack = 1'b1;
        jump           = 1'b1;
        jump_end       = 32'h300;
        for (int c = 0; c < 12; c++) begin
            checkOutput("halt_halted", 32'(halted_a),       32'd1);
            checkOutput("halt_req",    32'(bus_a.imem_req), 32'd0);
            checkOutput("halt_pc",     pc_a,                32'h102);
            checkOutput("halt_count",  count_a,             32'd11);
            @(negedge clock);
        end
        bus_a.imem_ack = 1'b0;
        jump           = 1'b0;

        reset_n = 1'b0;
        @(negedge clock);
        checkResetA("halt_reset");
        reset_n = 1'b1;
        applyStimulus(0, 0, 0, 1, 0, 32'h0,        32'h10,       32'h0,        0,   0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h10,       1,   1, 0);
        checkOutput("pre_reset_pc",  pc_a,                32'h11);
        checkOutput("pre_reset_req", 32'(bus_a.imem_req), 32'd1);
        bus_a.imem_ack = 1'b1;
        reset_n        = 1'b0;
        @(negedge clock);
        bus_a.imem_ack = 1'b0;
        checkResetA("fetch_reset");
        reset_n = 1'b1;
        applyStimulus(0, 0, 0, 1, 0, 32'h0,        32'h80,       32'h0,        0,   0, 1);
        checkResetA("exec_reset");
        reset_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0,   0, 0);

        @(negedge clock);
        checkOutput("queue_drained",     32'(exp_q.size()), 32'd0);
        checkOutput("req_valid_overlap", 32'(overlap_seen), 32'd0);
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    // Watchdog in case the sequencer wedges and a bounded wait is somehow bypassed
    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
